// File: rtl/inst_sequencer_pkg.sv
// Shared ISA definitions for the systolic-array control path: instruction width, opcodes, sequencer states.
// Opcodes outside IDLE/LOAD/MAT_MUL/WRITE/HALT are treated as illegal by the sequencer.
package inst_sequencer_pkg;

  localparam int ISA_BITS = 16;

  localparam logic [7:0] OP_IDLE         = 8'h00;
  localparam logic [7:0] OP_LOAD_DATA    = 8'h01;
  localparam logic [7:0] OP_LOAD_WEIGHT  = 8'h02;
  localparam logic [7:0] OP_MAT_MUL      = 8'h03;
  localparam logic [7:0] OP_WRITE_DATA   = 8'h04;
  localparam logic [7:0] OP_WRITE_WEIGHT = 8'h05;
  localparam logic [7:0] OP_WRITE_RESULT = 8'h06;
  localparam logic [7:0] OP_HALT         = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } seq_state_t;

  // Opcodes that are handed to the control unit and need a flag handshake.
  function automatic logic is_exec_op(input logic [7:0] op);
    return (op >= OP_LOAD_DATA) && (op <= OP_WRITE_RESULT);
  endfunction

  function automatic logic [7:0] opcode_of(input logic [ISA_BITS-1:0] inst);
    return inst[ISA_BITS-1 -: 8];
  endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Host/control-unit side bundle of inst_sequencer; master = host + control unit, slave = sequencer.
// timeout_err exists only when SEQ_TIMEOUT_EN is defined.
interface inst_sequencer_if #(
  parameter int DEPTH = 16
) ();
  import inst_sequencer_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ISA_BITS-1:0] inst_in;
  logic                inst_valid;
  logic                inst_ready;
  logic                start;
  logic                flag;
  logic [ISA_BITS-1:0] instruction;
  logic                busy;
  logic                done;
  logic [CW-1:0]       count;
  logic                illegal;
`ifdef SEQ_TIMEOUT_EN
  logic                timeout_err;

  modport master (
    output inst_in, inst_valid, start, flag,
    input  inst_ready, instruction, busy, done, count, illegal, timeout_err
  );

  modport slave (
    input  inst_in, inst_valid, start, flag,
    output inst_ready, instruction, busy, done, count, illegal, timeout_err
  );
`else
  modport master (
    output inst_in, inst_valid, start, flag,
    input  inst_ready, instruction, busy, done, count, illegal
  );

  modport slave (
    input  inst_in, inst_valid, start, flag,
    output inst_ready, instruction, busy, done, count, illegal
  );
`endif

endinterface

// File: rtl/inst_sequencer_fifo.sv
// inst_fifo: synchronous FIFO, count/head valid one edge after push/pop; push refused while full
// (no pop bypass), flush empties the queue and drops any same-cycle push.
module inst_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_acc;
  logic             pop_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  assign push_acc = push_vld && !full && !flush;
  assign pop_acc  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/inst_sequencer.sv
// Queues host instructions and issues them one at a time to the control unit, waiting for flag and
// inserting one idle gap between issues; start-to-issue 1 cycle. Optional watchdog: SEQ_TIMEOUT_EN.
module inst_sequencer
  import inst_sequencer_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             reset,
  inst_sequencer_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("inst_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
  end

  seq_state_t          state_q, state_d;
  logic [ISA_BITS-1:0] instr_q, instr_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;

  logic                pop;
  logic                flush;
  logic [ISA_BITS-1:0] head_dat;
  logic [7:0]          head_op;
  logic                full;
  logic                empty;
  logic [CW-1:0]       fifo_count;

  inst_fifo #(
    .WIDTH (ISA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .push_vld (bus.inst_valid),
    .push_dat (bus.inst_in),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count)
  );

  assign head_op = opcode_of(head_dat);

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_q, tmo_d;
`endif

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    wd_d      = wd_q;
    tmo_d     = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        instr_d = '0;
        if (bus.start) begin
          if (!empty) state_d = S_ISSUE;
          else        done_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (is_exec_op(head_op)) begin
          // The head stays queued until the control unit acknowledges it.
          instr_d = head_dat;
          state_d = S_WAIT;
`ifdef SEQ_TIMEOUT_EN
          wd_d    = '0;
`endif
        end else if (head_op == OP_HALT) begin
          pop     = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          pop       = 1'b1;
          illegal_d = (head_op != OP_IDLE);
          state_d   = S_GAP;
        end
      end
      S_WAIT: begin
        if (bus.flag) begin
          pop     = 1'b1;
          instr_d = '0;
          state_d = S_GAP;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Control unit never answered: abandon the whole program.
          tmo_d   = 1'b1;
          flush   = 1'b1;
          instr_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_GAP: begin
        instr_d = '0;
        if (!empty) begin
          state_d = S_ISSUE;
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        instr_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      tmo_q <= tmo_d;
    end
  end

  assign bus.timeout_err = tmo_q;
`endif

  assign bus.inst_ready  = !full;
  assign bus.count       = fifo_count;
  assign bus.instruction = instr_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// Bench for inst_sequencer: directed timing scenarios plus random programs against a queue-level model.
module tb_inst_sequencer;
  import inst_sequencer_pkg::*;

  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] issued_q[$];
  logic [15:0] prog_q[$];
  logic [15:0] exp_q[$];
  int ill_cnt, done_cnt, hold_err, gap_err;

  inst_sequencer_if #(.DEPTH(DEPTH)) bus ();

  inst_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.inst_in = '0; bus.inst_valid = 1'b0; bus.start = 1'b0; bus.flag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_entry(input logic [15:0] v);
    bus.inst_in = v; bus.inst_valid = 1'b1;
    @(negedge clk);
    bus.inst_valid = 1'b0;
  endtask

  // Control-unit stand-in: random flag latency, spurious flags while nothing is outstanding.
  task automatic run_prog(input int budget);
    logic [15:0] prev;
    int lat;
    bit real_flag, fin;
    issued_q.delete(); ill_cnt = 0; done_cnt = 0; hold_err = 0; gap_err = 0;
    prev = '0; lat = 0; real_flag = 0; fin = 0;
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      @(negedge clk);
      if (bus.illegal) ill_cnt++;
      if (real_flag && bus.instruction !== 16'h0) gap_err++;
      if (bus.instruction != 16'h0 && prev == 16'h0) begin
        issued_q.push_back(bus.instruction);
        lat = $urandom_range(0, 4);
      end else if (bus.instruction != 16'h0 && bus.instruction != prev) begin
        hold_err++;
      end
      prev = bus.instruction;
      bus.flag = 1'b0; real_flag = 0;
      if (bus.done) begin
        done_cnt++; fin = 1;
      end else if (bus.instruction != 16'h0) begin
        if (lat == 0) begin bus.flag = 1'b1; real_flag = 1; end
        else lat--;
      end else begin
        bus.flag = ($urandom_range(0, 3) == 0);
      end
    end
    bus.flag = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL run_prog_done_wait got no done within %0d cycles", budget); end
  endtask

  // Reference: what a program should do, from the opcode rules alone.
  task automatic model(output int exp_ill, output int rem);
    bit halted = 0;
    logic [7:0] op;
    exp_q.delete(); exp_ill = 0; rem = 0;
    foreach (prog_q[i]) begin
      op = prog_q[i][15:8];
      if (halted) rem++;
      else if (op == 8'hFF) halted = 1;
      else if (op >= 8'h01 && op <= 8'h06) exp_q.push_back(prog_q[i]);
      else if (op != 8'h00) exp_ill++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_inputs(); bus.inst_valid = 1'b1; bus.inst_in = 16'h0101;
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0) begin errors++; $display("FAIL reset_instruction got %h want 0", bus.instruction); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.inst_ready); end
    checks++; if (bus.count !== 0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.done !== 1'b0 || bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b illegal=%b want 0", bus.done, bus.illegal); end
    do_reset();
  endtask

  task automatic test_two_instr();
    do_reset();
    push_entry(16'h0110); push_entry(16'h0320);
    checks++; if (bus.count !== 2) begin errors++; $display("FAIL two_count got %0d want 2", bus.count); end
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    checks++; if (bus.instruction !== 16'h0 || bus.busy !== 1'b1) begin errors++; $display("FAIL two_issue_cycle got instr=%h busy=%b want 0/1", bus.instruction, bus.busy); end
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0110) begin errors++; $display("FAIL two_first_issue got %h want 0110", bus.instruction); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0110) begin errors++; $display("FAIL two_first_hold got %h want 0110", bus.instruction); end
    bus.flag = 1'b1; @(negedge clk); bus.flag = 1'b0;
    checks++; if (bus.instruction !== 16'h0 || bus.count !== 1) begin errors++; $display("FAIL two_after_flag got instr=%h count=%0d want 0/1", bus.instruction, bus.count); end
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0) begin errors++; $display("FAIL two_gap got %h want 0", bus.instruction); end
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0320) begin errors++; $display("FAIL two_second_issue got %h want 0320", bus.instruction); end
    @(negedge clk); @(negedge clk);
    bus.flag = 1'b1; @(negedge clk); bus.flag = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.instruction !== 16'h0) begin errors++; $display("FAIL two_last_flag got done=%b busy=%b instr=%h want 0/1/0", bus.done, bus.busy, bus.instruction); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.count !== 0) begin errors++; $display("FAIL two_done got done=%b busy=%b count=%0d want 1/0/0", bus.done, bus.busy, bus.count); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL two_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_halt();
    do_reset();
    push_entry(16'h0105); push_entry(16'hFF00); push_entry(16'h0206);
    run_prog(100);
    checks++; if (issued_q.size() != 1 || issued_q[0] !== 16'h0105) begin errors++; $display("FAIL halt_issued got %0d issues want only 0105", issued_q.size()); end
    checks++; if (done_cnt != 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL halt_done got done=%0d busy=%b want 1/0", done_cnt, bus.busy); end
    checks++; if (bus.count !== 1) begin errors++; $display("FAIL halt_remaining got %0d want 1", bus.count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_entry(16'h0100 | 16'(i));
    checks++; if (bus.inst_ready !== 1'b0 || bus.count !== DEPTH) begin errors++; $display("FAIL full_state got ready=%b count=%0d want 0/%0d", bus.inst_ready, bus.count, DEPTH); end
    bus.inst_in = 16'hDEAD; bus.inst_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.count !== DEPTH) begin errors++; $display("FAIL full_extra_push got %0d want %0d", bus.count, DEPTH); end
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0100) begin errors++; $display("FAIL full_issue got %h want 0100", bus.instruction); end
    bus.flag = 1'b1; @(negedge clk); bus.flag = 1'b0; bus.inst_valid = 1'b0;
    checks++; if (bus.count !== DEPTH - 1) begin errors++; $display("FAIL full_pop_push got %0d want %0d", bus.count, DEPTH - 1); end
    checks++; if (bus.inst_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b want 1", bus.inst_ready); end
  endtask

  task automatic test_illegal();
    do_reset();
    push_entry(16'h7700); push_entry(16'h0401);
    run_prog(100);
    checks++; if (ill_cnt != 1) begin errors++; $display("FAIL illegal_pulses got %0d want 1", ill_cnt); end
    checks++; if (issued_q.size() != 1 || issued_q[0] !== 16'h0401) begin errors++; $display("FAIL illegal_issued got %0d issues want only 0401", issued_q.size()); end
    checks++; if (done_cnt != 1 || bus.count !== 0) begin errors++; $display("FAIL illegal_end got done=%0d count=%0d want 1/0", done_cnt, bus.count); end
  endtask

  task automatic test_start_empty();
    do_reset();
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL empty_start got done=%b busy=%b want 1/0", bus.done, bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL empty_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_flag_ignored();
    do_reset();
    push_entry(16'h0202);
    bus.flag = 1'b1; repeat (3) @(negedge clk); bus.flag = 1'b0;
    checks++; if (bus.count !== 1 || bus.busy !== 1'b0 || bus.instruction !== 16'h0) begin errors++; $display("FAIL flag_idle got count=%0d busy=%b instr=%h want 1/0/0", bus.count, bus.busy, bus.instruction); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_entry(16'h0101); push_entry(16'h0202);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0101) begin errors++; $display("FAIL mid_issue got %h want 0101", bus.instruction); end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    checks++; if (bus.instruction !== 16'h0 || bus.count !== 0 || bus.busy !== 1'b0 || bus.inst_ready !== 1'b1) begin errors++; $display("FAIL mid_reset got instr=%h count=%0d busy=%b ready=%b want 0/0/0/1", bus.instruction, bus.count, bus.busy, bus.inst_ready); end
  endtask

  task automatic test_random();
    int n, r, exp_ill, rem;
    logic [7:0] op;
    logic [15:0] e;
    for (int t = 0; t < 24; t++) begin
      do_reset();
      prog_q.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 19);
        if (r < 13)      op = 8'($urandom_range(1, 6));
        else if (r < 15) op = 8'h00;
        else if (r < 18) op = 8'($urandom_range(7, 254));
        else             op = 8'hFF;
        e = {op, 8'($urandom_range(0, 255))};
        prog_q.push_back(e);
        push_entry(e);
      end
      model(exp_ill, rem);
      checks++; if (bus.count !== n) begin errors++; $display("FAIL rand_loaded t%0d got %0d want %0d", t, bus.count, n); end
      run_prog(400);
      checks++;
      if (issued_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_issue_count t%0d got %0d want %0d", t, issued_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++; if (issued_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_issue t%0d idx%0d got %h want %h", t, i, issued_q[i], exp_q[i]); end
        end
      end
      checks++; if (ill_cnt != exp_ill) begin errors++; $display("FAIL rand_illegal t%0d got %0d want %0d", t, ill_cnt, exp_ill); end
      checks++; if (bus.count !== rem || done_cnt != 1) begin errors++; $display("FAIL rand_end t%0d got count=%0d done=%0d want %0d/1", t, bus.count, done_cnt, rem); end
      checks++; if (hold_err != 0 || gap_err != 0) begin errors++; $display("FAIL rand_handshake t%0d got hold_err=%0d gap_err=%0d want 0/0", t, hold_err, gap_err); end
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    do_reset();
    push_entry(16'h0300); push_entry(16'h0101);
    bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    checks++; if (bus.instruction !== 16'h0300) begin errors++; $display("FAIL wd_issue got %h want 0300", bus.instruction); end
    repeat (TO - 1) @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b0 || bus.instruction !== 16'h0300) begin errors++; $display("FAIL wd_early got err=%b instr=%h want 0/0300", bus.timeout_err, bus.instruction); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b1 || bus.count !== 0 || bus.instruction !== 16'h0 || bus.done !== 1'b1) begin errors++; $display("FAIL wd_fire got err=%b count=%0d instr=%h done=%b want 1/0/0/1", bus.timeout_err, bus.count, bus.instruction, bus.done); end
    @(negedge clk);
    checks++; if (bus.timeout_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL wd_sticky got err=%b busy=%b want 1/0", bus.timeout_err, bus.busy); end
    do_reset();
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wd_reset got %b want 0", bus.timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_two_instr();
    test_halt();
    test_full();
    test_illegal();
    test_start_empty();
    test_flag_ignored();
    test_reset_mid();
    test_random();
`ifdef SEQ_TIMEOUT_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
